// File: rtl/gen3_packet_assembler_if.sv
// gen3_packet_assembler_if: classified byte stream in, committed packet byte stream out
interface gen3_packet_assembler_if;
  logic [7:0] data_in;
  logic       valid;
  logic [5:0] type_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       out_dllp;
  logic       pkt_drop;
  logic [1:0] drop_cause;
  modport master (
    output data_in, valid, type_in, out_ready,
    input  out_data, out_valid, out_sop, out_eop, out_dllp, pkt_drop, drop_cause
  );
  modport slave (
    input  data_in, valid, type_in, out_ready,
    output out_data, out_valid, out_sop, out_eop, out_dllp, pkt_drop, drop_cause
  );
endinterface

// File: rtl/gen3_packet_assembler.sv
// gen3_packet_assembler: store-and-forward assembler that releases only complete TLP/DLLP packets
module gen3_packet_assembler #(
  parameter int ADDR_W = 11
) (
  input logic clk,
  input logic rst,
  gen3_packet_assembler_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [5:0] T_DATA = 6'b100000;
  localparam logic [5:0] T_TS   = 6'b010000;
  localparam logic [5:0] T_TE   = 6'b101000;
  localparam logic [5:0] T_DS   = 6'b000010;
  localparam logic [5:0] T_DE   = 6'b100100;
  localparam logic [5:0] T_EDB  = 6'b000001;
  typedef enum logic [1:0] {IDLE, TLP, DLLP, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, start_ptr_q, start_ptr_d;
  logic pkt_drop_q, pkt_drop_d;
  logic [1:0] drop_cause_q, drop_cause_d;
  logic [10:0] mem [DEPTH];
  logic [10:0] head, wdata;
  logic avail, is_data, is_start, is_end, is_edb, in_pkt, match_end, full, we;
  assign is_data   = bus.valid && bus.type_in == T_DATA;
  assign is_start  = bus.valid && (bus.type_in == T_TS || bus.type_in == T_DS);
  assign is_end    = bus.valid && (bus.type_in == T_TE || bus.type_in == T_DE);
  assign is_edb    = bus.valid && bus.type_in == T_EDB;
  assign in_pkt    = state_q == TLP || state_q == DLLP;
  assign match_end = bus.valid && ((state_q == TLP && bus.type_in == T_TE) ||
                                   (state_q == DLLP && bus.type_in == T_DE));
  // occupancy counts uncommitted bytes too, measured against the pre-edge read pointer
  assign full  = wr_ptr_q - rd_ptr_q == (ADDR_W + 1)'(DEPTH);
  assign avail = rd_ptr_q != commit_ptr_q;
  assign head  = mem[rd_ptr_q[ADDR_W-1:0]];
  assign wdata = {state_q == DLLP, match_end, wr_ptr_q == start_ptr_q, bus.data_in};
  assign bus.out_valid  = avail;
  assign bus.out_data   = avail ? head[7:0] : 8'd0;
  assign bus.out_sop    = avail && head[8];
  assign bus.out_eop    = avail && head[9];
  assign bus.out_dllp   = avail && head[10];
  assign bus.pkt_drop   = pkt_drop_q;
  assign bus.drop_cause = drop_cause_q;
  assign rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(avail && bus.out_ready);
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    start_ptr_d  = start_ptr_q;
    pkt_drop_d   = 1'b0;
    drop_cause_d = 2'd0;
    we           = 1'b0;
    if (is_start) begin
      state_d = bus.type_in == T_TS ? TLP : DLLP;
      if (in_pkt) begin
        wr_ptr_d     = start_ptr_q;
        pkt_drop_d   = 1'b1;
        drop_cause_d = 2'd2;
      end else begin
        start_ptr_d = wr_ptr_q;
      end
    end else if (in_pkt) begin
      if ((is_data || match_end) && full) begin
        wr_ptr_d     = start_ptr_q;
        pkt_drop_d   = 1'b1;
        drop_cause_d = 2'd1;
        state_d      = DROP;
      end else if (is_data || match_end) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (match_end) begin
          commit_ptr_d = wr_ptr_q + 1'b1;
          state_d      = IDLE;
        end
      end else if (is_edb || is_end) begin
        wr_ptr_d     = start_ptr_q;
        pkt_drop_d   = 1'b1;
        drop_cause_d = is_edb ? 2'd0 : 2'd3;
        state_d      = IDLE;
      end
    end else if (state_q == DROP && (is_end || is_edb)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      start_ptr_q  <= '0;
      pkt_drop_q   <= 1'b0;
      drop_cause_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      start_ptr_q  <= start_ptr_d;
      pkt_drop_q   <= pkt_drop_d;
      drop_cause_q <= drop_cause_d;
    end
  end
endmodule
